// File: rtl/priority_scan_enc.sv
// Sequential priority encoder: accepts a multi-hot vector, then reports
// every set index one beat at a time in priority order.
module priority_scan_enc #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDXW     = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last,
    output logic              out_none,
    output logic [IDXW:0]     out_count
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              last_q, last_d;
    logic              none_q, none_d;
    logic [IDXW:0]     count_q, count_d;

    logic [WIDTH-1:0]  src;
    logic [WIDTH-1:0]  rem;
    logic [IDXW-1:0]   sel;
    logic              accept;
    logic              xfer;

    function automatic logic [IDXW-1:0] pick(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        // Later hits overwrite earlier ones, so loop direction sets priority.
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (v[i]) r = IDXW'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    function automatic logic [IDXW:0] popcnt(input logic [WIDTH-1:0] v);
        logic [IDXW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + {{IDXW{1'b0}}, v[i]};
        return c;
    endfunction

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign out_none  = none_q;
    assign out_count = count_q;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    // One lookup per cycle: on the fresh vector when idle, else on the remainder.
    assign src = (state_q == IDLE) ? in_vec : pending_q;
    assign sel = pick(src);
    assign rem = src & ~({{(WIDTH-1){1'b0}}, 1'b1} << sel);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        last_d    = last_q;
        none_d    = none_q;
        count_d   = count_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SCAN;
                    pending_d = rem;
                    idx_d     = sel;
                    last_d    = (rem == '0);
                    none_d    = (in_vec == '0);
                    count_d   = popcnt(in_vec);
                end
            end
            SCAN: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d   = IDLE;
                        pending_d = '0;
                        idx_d     = '0;
                        last_d    = 1'b0;
                        none_d    = 1'b0;
                        count_d   = '0;
                    end else begin
                        pending_d = rem;
                        idx_d     = sel;
                        last_d    = (rem == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            none_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            none_q    <= none_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_priority_scan_enc.sv
// Bench for priority_scan_enc: four instances (8/16 bit, both priority
// orders) driven by directed and random vectors against a list model.
module tb_priority_scan_enc;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv[4];
    logic        orr[4];
    logic [15:0] ivec[4];
    logic        ir[4];
    logic        ov[4];
    logic        ol[4];
    logic        on_[4];
    logic [3:0]  oi[4];
    logic [4:0]  oc[4];

    logic [2:0]  oi8[2];
    logic [3:0]  oc8[2];
    logic [3:0]  oi16[2];
    logic [4:0]  oc16[2];

    int wd[4]   = '{8, 8, 16, 16};
    bit msbf[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    int total = 0;
    int bad   = 0;

    always_comb begin
        oi[0] = {1'b0, oi8[0]};
        oi[1] = {1'b0, oi8[1]};
        oi[2] = oi16[0];
        oi[3] = oi16[1];
        oc[0] = {1'b0, oc8[0]};
        oc[1] = {1'b0, oc8[1]};
        oc[2] = oc16[0];
        oc[3] = oc16[1];
    end

    priority_scan_enc #(.WIDTH(8), .MSB_FIRST(1'b1)) u_d0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_vec(ivec[0][7:0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_idx(oi8[0]),
        .out_last(ol[0]), .out_none(on_[0]), .out_count(oc8[0]));

    priority_scan_enc #(.WIDTH(8), .MSB_FIRST(1'b0)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_vec(ivec[1][7:0]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_idx(oi8[1]),
        .out_last(ol[1]), .out_none(on_[1]), .out_count(oc8[1]));

    priority_scan_enc #(.WIDTH(16), .MSB_FIRST(1'b1)) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_vec(ivec[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .out_idx(oi16[0]),
        .out_last(ol[2]), .out_none(on_[2]), .out_count(oc16[0]));

    priority_scan_enc #(.WIDTH(16), .MSB_FIRST(1'b0)) u_d3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[3]), .in_ready(ir[3]), .in_vec(ivec[3]),
        .out_valid(ov[3]), .out_ready(orr[3]), .out_idx(oi16[1]),
        .out_last(ol[3]), .out_none(on_[3]), .out_count(oc16[1]));

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Reference: list of set indices in the order the instance must report.
    task automatic model(input int k, input logic [15:0] vec, output int q[$]);
        q = {};
        if (msbf[k]) begin
            for (int i = wd[k] - 1; i >= 0; i--)
                if (vec[i]) q.push_back(i);
        end else begin
            for (int i = 0; i < wd[k]; i++)
                if (vec[i]) q.push_back(i);
        end
    endtask

    task automatic wait_ready(input int k);
        int cyc;
        cyc = 0;
        while (ir[k] !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_idle", k, 32'(ir[k]), 32'd1);
    endtask

    task automatic run_vec(input int k, input logic [15:0] vec,
                           input int stall0, input bit rnd, input bit hold);
        int q[$];
        int nb;
        int s;
        logic [15:0] mask;
        mask = (wd[k] == 16) ? 16'hFFFF : 16'h00FF;
        vec = vec & mask;
        model(k, vec, q);
        nb = (q.size() == 0) ? 1 : q.size();
        wait_ready(k);
        iv[k]   = 1'b1;
        ivec[k] = vec;
        @(negedge clk);
        if (hold) ivec[k] = ~vec & mask;
        else      iv[k]   = 1'b0;
        chk("latency1_valid", k, 32'(ov[k]), 32'd1);
        for (int j = 0; j < nb; j++) begin
            if (j == 0 && stall0 >= 0) s = stall0;
            else s = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int t = 0; t <= s; t++) begin
                orr[k] = (t == s);
                chk("beat_valid", k, 32'(ov[k]), 32'd1);
                chk("beat_idx", k, 32'(oi[k]),
                    (q.size() == 0) ? 32'd0 : 32'(q[j]));
                chk("beat_last", k, 32'(ol[k]), 32'(j == nb - 1));
                chk("beat_none", k, 32'(on_[k]), 32'(q.size() == 0));
                chk("beat_count", k, 32'(oc[k]), 32'(q.size()));
                chk("busy_in_ready", k, 32'(ir[k]), 32'd0);
                @(negedge clk);
            end
            orr[k] = 1'b0;
        end
        iv[k] = 1'b0;
        chk("done_valid", k, 32'(ov[k]), 32'd0);
        chk("done_in_ready", k, 32'(ir[k]), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int k;
        for (int i = 0; i < 4; i++) begin
            iv[i]   = 1'b0;
            orr[i]  = 1'b0;
            ivec[i] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_in_ready", i, 32'(ir[i]), 32'd0);
            chk("rst_idx", i, 32'(oi[i]), 32'd0);
            chk("rst_count", i, 32'(oc[i]), 32'd0);
            chk("rst_last", i, 32'(ol[i]), 32'd0);
            chk("rst_none", i, 32'(on_[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk("post_rst_ready", i, 32'(ir[i]), 32'd1);

        run_vec(0, 16'h00A6, 0, 1'b0, 1'b0);
        run_vec(1, 16'h00A6, 0, 1'b0, 1'b0);
        run_vec(0, 16'h0000, 0, 1'b0, 1'b0);
        run_vec(1, 16'h0000, 0, 1'b0, 1'b1);
        run_vec(0, 16'h0081, 3, 1'b0, 1'b0);
        run_vec(1, 16'h0080, 1, 1'b0, 1'b1);
        run_vec(2, 16'h8001, 0, 1'b0, 1'b0);
        run_vec(3, 16'hFFFF, 2, 1'b1, 1'b1);

        // Asynchronous reset in the middle of an 8'hFF scan.
        wait_ready(0);
        iv[0]   = 1'b1;
        ivec[0] = 16'h00FF;
        @(negedge clk);
        iv[0]  = 1'b0;
        orr[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("pre_rst_idx", 0, 32'(oi[0]), 32'(7 - j));
            @(negedge clk);
        end
        orr[0] = 1'b0;
        chk("pre_rst_idx4", 0, 32'(oi[0]), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 0, 32'(ov[0]), 32'd0);
        chk("mid_rst_in_ready", 0, 32'(ir[0]), 32'd0);
        chk("mid_rst_idx", 0, 32'(oi[0]), 32'd0);
        chk("mid_rst_count", 0, 32'(oc[0]), 32'd0);
        chk("mid_rst_last", 0, 32'(ol[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_ready", 0, 32'(ir[0]), 32'd1);
        chk("after_rst_valid", 0, 32'(ov[0]), 32'd0);
        run_vec(0, 16'h0010, 0, 1'b0, 1'b0);

        repeat (80) begin
            k = int'($urandom_range(0, 3));
            r = $urandom;
            if ($urandom_range(0, 7) == 0) r = '0;
            run_vec(k, r[15:0], -1, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
